// File: rtl/munoc_slave_write_issuer.sv
// Slave-side AXI write issuer: turns decoded network write headers and data beats
// into AXI AW/W traffic and routes B responses back to the originating master node.
module munoc_slave_write_issuer #(
    parameter int BW_ADDR = 32,
    parameter int BW_DATA = 64,
    parameter int BW_TID  = 8,
    parameter int BW_MID  = 4,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rstnn,
    input  logic                 req_hvalid,
    output logic                 req_hready,
    input  logic [BW_ADDR-1:0]   req_addr,
    input  logic [BW_MID-1:0]    req_mid,
    input  logic [BW_TID-1:0]    req_tid,
    input  logic [7:0]           req_len,
    input  logic [2:0]           req_size,
    input  logic [1:0]           req_burst,
    input  logic                 req_dvalid,
    output logic                 req_dready,
    input  logic [BW_DATA-1:0]   req_wdata,
    input  logic [BW_DATA/8-1:0] req_wstrb,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [BW_TID-1:0]    awid,
    output logic [BW_ADDR-1:0]   awaddr,
    output logic [7:0]           awlen,
    output logic [2:0]           awsize,
    output logic [1:0]           awburst,
    output logic                 wvalid,
    input  logic                 wready,
    output logic [BW_DATA-1:0]   wdata,
    output logic [BW_DATA/8-1:0] wstrb,
    output logic                 wlast,
    input  logic                 bvalid,
    output logic                 bready,
    input  logic [BW_TID-1:0]    bid,
    input  logic [1:0]           bresp,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BW_MID-1:0]    rsp_mid,
    output logic [BW_TID-1:0]    rsp_tid,
    output logic [1:0]           rsp_resp,
    output logic                 order_err
);

    localparam int BW_PTR = $clog2(DEPTH);
    localparam int BW_CNT = BW_PTR + 1;
    localparam logic [BW_CNT-1:0] CNT_MAX = BW_CNT'(DEPTH);
    localparam logic [BW_CNT-1:0] CNT_ONE = BW_CNT'(1);
    localparam logic [BW_PTR-1:0] PTR_ONE = BW_PTR'(1);

    logic [BW_CNT-1:0]  r_cnt;
    logic [BW_CNT-1:0]  r_wq_cnt;
    logic [BW_PTR-1:0]  r_of_wptr, r_of_rptr;
    logic [BW_PTR-1:0]  r_wq_wptr, r_wq_rptr;
    logic [BW_MID-1:0]  r_of_mid [DEPTH];
    logic [BW_TID-1:0]  r_of_tid [DEPTH];
    logic [7:0]         r_wq_len [DEPTH];
    logic [7:0]         r_beat;
    logic               r_awvalid;
    logic [BW_TID-1:0]  r_awid;
    logic [BW_ADDR-1:0] r_awaddr;
    logic [7:0]         r_awlen;
    logic [2:0]         r_awsize;
    logic [1:0]         r_awburst;
    logic               r_order_err;

    logic w_hdr_acc, w_cnt_nz, w_wq_ne, w_wlast, w_w_hs, w_w_last_hs, w_b_hs;

    assign w_cnt_nz    = (r_cnt != '0);
    assign w_wq_ne     = (r_wq_cnt != '0);
    assign req_hready  = (r_cnt < CNT_MAX) && (!r_awvalid || awready);
    assign w_hdr_acc   = req_hvalid && req_hready;

    // W beats flow straight through; only the length queue gates them
    assign wvalid      = req_dvalid && w_wq_ne;
    assign req_dready  = wready && w_wq_ne;
    assign wdata       = req_wdata;
    assign wstrb       = req_wstrb;
    assign w_wlast     = w_wq_ne && (r_beat == r_wq_len[r_wq_rptr]);
    assign wlast       = w_wlast;
    assign w_w_hs      = wvalid && wready;
    assign w_w_last_hs = w_w_hs && w_wlast;

    assign rsp_valid   = bvalid && w_cnt_nz;
    assign bready      = rsp_ready && w_cnt_nz;
    assign w_b_hs      = bvalid && bready;
    assign rsp_mid     = r_of_mid[r_of_rptr];
    assign rsp_tid     = bid;
    assign rsp_resp    = bresp;
    assign order_err   = r_order_err;

    assign awvalid     = r_awvalid;
    assign awid        = r_awid;
    assign awaddr      = r_awaddr;
    assign awlen       = r_awlen;
    assign awsize      = r_awsize;
    assign awburst     = r_awburst;

    // AW fields only load on accept, and accept needs !awvalid || awready,
    // so a pending AW never changes under the slave.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_awvalid <= 1'b0;
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
        end else if (w_hdr_acc) begin
            r_awvalid <= 1'b1;
            r_awid    <= req_tid;
            r_awaddr  <= req_addr;
            r_awlen   <= req_len;
            r_awsize  <= req_size;
            r_awburst <= req_burst;
        end else if (awready) begin
            r_awvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_cnt       <= '0;
            r_of_wptr   <= '0;
            r_of_rptr   <= '0;
            r_order_err <= 1'b0;
        end else begin
            case ({w_hdr_acc, w_b_hs})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
            if (w_hdr_acc) r_of_wptr <= r_of_wptr + PTR_ONE;
            if (w_b_hs) begin
                r_of_rptr <= r_of_rptr + PTR_ONE;
                if (bid != r_of_tid[r_of_rptr]) r_order_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_wq_cnt  <= '0;
            r_wq_wptr <= '0;
            r_wq_rptr <= '0;
            r_beat    <= '0;
        end else begin
            case ({w_hdr_acc, w_w_last_hs})
                2'b10:   r_wq_cnt <= r_wq_cnt + CNT_ONE;
                2'b01:   r_wq_cnt <= r_wq_cnt - CNT_ONE;
                default: r_wq_cnt <= r_wq_cnt;
            endcase
            if (w_hdr_acc)   r_wq_wptr <= r_wq_wptr + PTR_ONE;
            if (w_w_last_hs) r_wq_rptr <= r_wq_rptr + PTR_ONE;
            if (w_w_hs)      r_beat    <= w_wlast ? 8'd0 : r_beat + 8'd1;
        end
    end

    // Storage needs no reset: entries are only read behind a valid pointer/count
    always_ff @(posedge clk) begin
        if (w_hdr_acc) begin
            r_of_mid[r_of_wptr] <= req_mid;
            r_of_tid[r_of_wptr] <= req_tid;
            r_wq_len[r_wq_wptr] <= req_len;
        end
    end

endmodule

// File: tb/tb_munoc_slave_write_issuer.sv
// Directed bench for munoc_slave_write_issuer: single write, outstanding limit,
// AW backpressure, len 0/255 bursts, B order errors and mid-burst reset.
module tb_munoc_slave_write_issuer;

    logic        clk = 1'b0;
    logic        rstnn = 1'b0;
    logic        req_hvalid = 1'b0, req_hready;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_mid = '0;
    logic [7:0]  req_tid = '0, req_len = '0;
    logic [2:0]  req_size = '0;
    logic [1:0]  req_burst = '0;
    logic        req_dvalid = 1'b0, req_dready;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        awvalid, awready = 1'b0;
    logic [7:0]  awid, awlen;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready = 1'b0;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid = 1'b0, bready;
    logic [7:0]  bid = '0;
    logic [1:0]  bresp = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [3:0]  rsp_mid;
    logic [7:0]  rsp_tid;
    logic [1:0]  rsp_resp;
    logic        order_err;

    int n_chk = 0;
    int n_err = 0;

    munoc_slave_write_issuer dut (
        .clk(clk), .rstnn(rstnn),
        .req_hvalid(req_hvalid), .req_hready(req_hready), .req_addr(req_addr),
        .req_mid(req_mid), .req_tid(req_tid), .req_len(req_len),
        .req_size(req_size), .req_burst(req_burst),
        .req_dvalid(req_dvalid), .req_dready(req_dready),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mid(rsp_mid),
        .rsp_tid(rsp_tid), .rsp_resp(rsp_resp), .order_err(order_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req_hvalid = 1'b0; req_dvalid = 1'b0; bvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rstnn = 1'b0;
        repeat (2) @(negedge clk);
        rstnn = 1'b1;
    endtask

    task automatic hdr(input logic [31:0] a, input logic [3:0] m, input logic [7:0] t,
                       input logic [7:0] l);
        req_hvalid = 1'b1; req_addr = a; req_mid = m; req_tid = t; req_len = l;
        req_size = 3'd3; req_burst = 2'd1;
    endtask

    initial begin
        int sent, cyc, nlast;
        // reset state, with every upstream valid raised
        req_dvalid = 1'b1; bvalid = 1'b1; rsp_ready = 1'b1; wready = 1'b1;
        #12;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_dready", req_dready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_order_err", order_err, 0);
        do_reset();
        #1 chk("rst_hready", req_hready, 1);

        // single write len=3
        @(negedge clk);
        awready = 1'b1; wready = 1'b1; rsp_ready = 1'b1;
        hdr(32'h1000, 4'd2, 8'h12, 8'd3);
        #1 chk("t1_hready", req_hready, 1);
        chk("t1_awvalid_pre", awvalid, 0);
        @(negedge clk);
        req_hvalid = 1'b0;
        chk("t1_awvalid", awvalid, 1);
        chk("t1_awid", awid, 8'h12);
        chk("t1_awaddr", awaddr, 32'h1000);
        chk("t1_awlen", awlen, 3);
        req_dvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_wdata = 64'hA000 + 64'(k);
            #1 chk("t1_wvalid", wvalid, 1);
            chk("t1_wlast", wlast, (k == 3));
            chk("t1_wdata", wdata, 64'hA000 + 64'(k));
            @(negedge clk);
        end
        #1 chk("t1_wvalid_done", wvalid, 0);
        req_dvalid = 1'b0;
        bvalid = 1'b1; bid = 8'h12; bresp = 2'd0;
        #1 chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_mid", rsp_mid, 2);
        chk("t1_rsp_tid", rsp_tid, 8'h12);
        chk("t1_bready", bready, 1);
        @(negedge clk);
        #1 chk("t1_cnt0_rsp", rsp_valid, 0);
        chk("t1_cnt0_bready", bready, 0);
        chk("t1_order_err", order_err, 0);
        bvalid = 1'b0;

        // outstanding limit: 5 headers, no B
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            hdr(32'h100 * i, 4'(i), 8'(i), 8'd0);
            #1 chk($sformatf("t2_hready_%0d", i), req_hready, (i <= 4));
        end
        @(negedge clk);
        bvalid = 1'b1; bid = 8'd1;
        #1 chk("t2_full_hready", req_hready, 0);
        chk("t2_rsp_mid", rsp_mid, 1);
        @(negedge clk);
        bvalid = 1'b0;
        #1 chk("t2_hready_after_b", req_hready, 1);
        @(negedge clk);
        req_hvalid = 1'b0;
        chk("t2_awvalid5", awvalid, 1);
        chk("t2_awid5", awid, 5);
        do_reset();

        // AW backpressure for 10 cycles
        @(negedge clk);
        hdr(32'h2000, 4'd1, 8'h33, 8'd1);
        @(negedge clk);
        hdr(32'h3000, 4'd1, 8'h44, 8'd1);
        for (int i = 0; i < 10; i++) begin
            #1 chk("t3_awvalid", awvalid, 1);
            chk("t3_awid", awid, 8'h33);
            chk("t3_awaddr", awaddr, 32'h2000);
            chk("t3_hready", req_hready, 0);
            @(negedge clk);
        end
        awready = 1'b1;
        #1 chk("t3_hready_awready", req_hready, 1);
        @(negedge clk);
        req_hvalid = 1'b0;
        chk("t3_awid2", awid, 8'h44);
        chk("t3_awaddr2", awaddr, 32'h3000);
        @(negedge clk);
        chk("t3_aw_clear", awvalid, 0);
        do_reset();

        // len=0 then len=255, wready toggling
        @(negedge clk);
        awready = 1'b1;
        hdr(32'h4000, 4'd1, 8'h50, 8'd0);
        @(negedge clk);
        hdr(32'h5000, 4'd3, 8'h51, 8'd255);
        @(negedge clk);
        req_hvalid = 1'b0;
        req_dvalid = 1'b1;
        sent = 0; cyc = 0; nlast = 0;
        while (sent < 257 && cyc < 1200) begin
            wready = cyc[0];
            req_wdata = 64'(sent);
            #1;
            if (wvalid && wready) begin
                chk($sformatf("t4_wlast_%0d", sent), wlast, (sent == 0 || sent == 256));
                if (wlast) nlast++;
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("t4_beats", sent, 257);
        chk("t4_nlast", nlast, 2);
        wready = 1'b1;
        #1 chk("t4_drained", wvalid, 0);
        req_dvalid = 1'b0;

        // B order error, sticky
        rsp_ready = 1'b1; bvalid = 1'b1; bid = 8'h99; bresp = 2'd2;
        #1 chk("t5_rsp_mid", rsp_mid, 1);
        chk("t5_rsp_tid", rsp_tid, 8'h99);
        chk("t5_rsp_resp", rsp_resp, 2);
        chk("t5_err_pre", order_err, 0);
        @(negedge clk);
        chk("t5_err_set", order_err, 1);
        bid = 8'h51; bresp = 2'd0;
        #1 chk("t5_rsp_mid2", rsp_mid, 3);
        @(negedge clk);
        bvalid = 1'b0;
        chk("t5_err_sticky", order_err, 1);

        // mid-burst reset
        awready = 1'b0;
        hdr(32'h6000, 4'd4, 8'h60, 8'd3);
        @(negedge clk);
        req_hvalid = 1'b0; req_dvalid = 1'b1; wready = 1'b1;
        repeat (2) @(negedge clk);
        bvalid = 1'b1;
        #1 rstnn = 1'b0;
        #1 chk("t6_awvalid", awvalid, 0);
        chk("t6_wvalid", wvalid, 0);
        chk("t6_dready", req_dready, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_bready", bready, 0);
        chk("t6_order_err", order_err, 0);
        chk("t6_hready", req_hready, 1);
        @(negedge clk);
        rstnn = 1'b1;
        bvalid = 1'b0;
        @(negedge clk);
        chk("t6_no_resume", wvalid, 0);

        // fresh write after reset starts at beat 0
        awready = 1'b1;
        hdr(32'h7000, 4'd5, 8'h70, 8'd1);
        @(negedge clk);
        req_hvalid = 1'b0;
        #1 chk("t7_wlast0", wlast, 0);
        chk("t7_wvalid", wvalid, 1);
        @(negedge clk);
        #1 chk("t7_wlast1", wlast, 1);
        @(negedge clk);
        req_dvalid = 1'b0;
        bvalid = 1'b1; bid = 8'h70;
        #1 chk("t7_rsp_mid", rsp_mid, 5);
        @(negedge clk);
        bvalid = 1'b0;
        chk("t7_order_err", order_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
